// File: rtl/ibex_instr_wb_bridge.sv
// Ibex instruction-fetch (req/gnt/rvalid) to Wishbone B4 pipelined read master.
// Bounds outstanding reads and aborts a hung bus with timeout error responses.
module ibex_instr_wb_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [29:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    output logic        timeout_o,
    output logic        spurious_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [2:0] MAX_C = 3'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [2:0]    abort_q, abort_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_q, timeout_d;
    logic          spurious_q, spurious_d;

    logic        bus_resp;
    logic        live;
    logic        resp;
    logic        stb;
    logic        gnt;
    logic        cyc;
    logic        rvalid;
    logic        rerr;
    logic [31:0] rdata;
    logic        unused_addr;

    assign bus_resp    = wb_ack_i | wb_err_i;
    assign live        = (cnt_q != 3'd0);
    assign unused_addr = ^instr_addr_i[1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        abort_d    = abort_q;
        timer_d    = timer_q;
        timeout_d  = timeout_q;
        spurious_d = spurious_q;
        resp       = 1'b0;
        stb        = 1'b0;
        gnt        = 1'b0;
        cyc        = 1'b0;
        rvalid     = 1'b0;
        rerr       = 1'b0;
        rdata      = wb_dat_i;
        unique case (state_q)
            IDLE, BUSY: begin
                resp   = bus_resp & live;
                // A response this cycle frees a slot for a same-cycle issue.
                stb    = instr_req_i & ((cnt_q < MAX_C) | resp);
                gnt    = stb & ~wb_stall_i;
                cyc    = stb | live;
                rvalid = resp;
                rerr   = wb_err_i & live;
                if (bus_resp && !live) begin
                    spurious_d = 1'b1;
                end
                cnt_d = cnt_q + 3'(gnt) - 3'(resp);
                if (state_q == IDLE) begin
                    timer_d = '0;
                    if (gnt) begin
                        state_d = BUSY;
                    end
                end else begin
                    if (resp) begin
                        timer_d = '0;
                    end else if (TO_EN) begin
                        timer_d = timer_q + 1'b1;
                    end
                    if (TO_EN && timer_q == T_LAST && !resp) begin
                        state_d   = ABORT;
                        abort_d   = cnt_d;
                        cnt_d     = 3'd0;
                        timer_d   = '0;
                        timeout_d = 1'b1;
                    end else if (cnt_d == 3'd0 && !gnt) begin
                        state_d = IDLE;
                    end
                end
            end
            ABORT: begin
                rdata = '0;
                if (abort_q != 3'd0) begin
                    rvalid  = 1'b1;
                    rerr    = 1'b1;
                    abort_d = abort_q - 3'd1;
                end
                if (abort_d == 3'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            abort_q    <= 3'd0;
            timer_q    <= '0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            timer_q    <= timer_d;
            timeout_q  <= timeout_d;
            spurious_q <= spurious_d;
        end
    end

    // Bus controls drop the instant reset rises, even with a request held.
    assign wb_stb_o       = stb & ~rst_i;
    assign wb_cyc_o       = cyc & ~rst_i;
    assign instr_gnt_o    = gnt & ~rst_i;
    assign instr_rvalid_o = rvalid & ~rst_i;
    assign instr_err_o    = rerr & ~rst_i;
    assign instr_rdata_o  = rdata;
    assign wb_adr_o       = instr_addr_i[31:2];
    assign wb_sel_o       = 4'hF;
    assign wb_we_o        = 1'b0;
    assign timeout_o      = timeout_q;
    assign spurious_o     = spurious_q;

endmodule

// File: tb/tb_ibex_instr_wb_bridge.sv
// Directed self-checking bench for ibex_instr_wb_bridge.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_ibex_instr_wb_bridge;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rerr;
    logic        cyc;
    logic        stb;
    logic [29:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic        stall;
    logic        tmo;
    logic        spur;

    int checks = 0;
    int errors = 0;

    ibex_instr_wb_bridge #(
        .MAX_OUTSTANDING(2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_req_i   (req),
        .instr_addr_i  (addr),
        .instr_gnt_o   (gnt),
        .instr_rvalid_o(rvalid),
        .instr_rdata_o (rdata),
        .instr_err_o   (rerr),
        .wb_cyc_o      (cyc),
        .wb_stb_o      (stb),
        .wb_adr_o      (adr),
        .wb_sel_o      (sel),
        .wb_we_o       (we),
        .wb_dat_i      (dat),
        .wb_ack_i      (ack),
        .wb_err_i      (err),
        .wb_stall_i    (stall),
        .timeout_o     (tmo),
        .spurious_o    (spur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 1'b0;
        addr  = '0;
        dat   = '0;
        ack   = 1'b0;
        err   = 1'b0;
        stall = 1'b0;
        #3;
        chk("rst_cyc", 32'(cyc), 0);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_err", 32'(rerr), 0);
        chk("rst_tmo", 32'(tmo), 0);
        chk("rst_spur", 32'(spur), 0);
        chk("rst_sel", 32'(sel), 32'hF);
        chk("rst_we", 32'(we), 0);
        tick();
        rst = 1'b0;

        // 1: single fetch
        tick();
        req = 1'b1; addr = 32'h100;
        #1;
        chk("t1_stb", 32'(stb), 1);
        chk("t1_gnt", 32'(gnt), 1);
        chk("t1_adr", 32'(adr), 32'h40);
        chk("t1_cyc", 32'(cyc), 1);
        tick();
        req = 1'b0; ack = 1'b1; dat = 32'hDEADBEEF;
        #1;
        chk("t1_rvalid", 32'(rvalid), 1);
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        chk("t1_err", 32'(rerr), 0);
        tick();
        ack = 1'b0;
        #1;
        chk("t1_cyc_low", 32'(cyc), 0);
        chk("t1_rvalid_low", 32'(rvalid), 0);

        // 2: stall for three cycles
        tick();
        req = 1'b1; addr = 32'h200; stall = 1'b1;
        #1;
        chk("t2_stb0", 32'(stb), 1);
        chk("t2_gnt0", 32'(gnt), 0);
        tick();
        #1;
        chk("t2_gnt1", 32'(gnt), 0);
        tick();
        #1;
        chk("t2_gnt2", 32'(gnt), 0);
        chk("t2_stb2", 32'(stb), 1);
        tick();
        stall = 1'b0;
        #1;
        chk("t2_gnt3", 32'(gnt), 1);
        tick();
        req = 1'b0;
        #1;
        chk("t2_cyc_held", 32'(cyc), 1);
        chk("t2_stb_low", 32'(stb), 0);
        tick();
        ack = 1'b1; dat = 32'h11111111;
        #1;
        chk("t2_rvalid", 32'(rvalid), 1);
        tick();
        ack = 1'b0;
        #1;
        chk("t2_cyc_low", 32'(cyc), 0);

        // 3: outstanding limit and same-cycle release
        tick();
        req = 1'b1; addr = 32'h300;
        #1;
        chk("t3_gnt_a", 32'(gnt), 1);
        tick();
        addr = 32'h304;
        #1;
        chk("t3_gnt_b", 32'(gnt), 1);
        tick();
        addr = 32'h308;
        #1;
        chk("t3_stb_full", 32'(stb), 0);
        chk("t3_gnt_full", 32'(gnt), 0);
        chk("t3_cyc_full", 32'(cyc), 1);
        tick();
        ack = 1'b1; dat = 32'hA1A1A1A1;
        #1;
        chk("t3_rvalid_a", 32'(rvalid), 1);
        chk("t3_rdata_a", rdata, 32'hA1A1A1A1);
        chk("t3_gnt_c", 32'(gnt), 1);
        chk("t3_adr_c", 32'(adr), 32'hC2);
        tick();
        req = 1'b0; ack = 1'b0;
        #1;
        chk("t3_cyc_two", 32'(cyc), 1);
        tick();
        ack = 1'b1; dat = 32'hA2A2A2A2;
        #1;
        chk("t3_rdata_b", rdata, 32'hA2A2A2A2);
        chk("t3_rvalid_b", 32'(rvalid), 1);
        tick();
        dat = 32'hA3A3A3A3;
        #1;
        chk("t3_rvalid_c", 32'(rvalid), 1);
        tick();
        ack = 1'b0;
        #1;
        chk("t3_cyc_low", 32'(cyc), 0);

        // 4: error on second of two reads
        tick();
        req = 1'b1; addr = 32'h400;
        #1;
        chk("t4_gnt_a", 32'(gnt), 1);
        tick();
        addr = 32'h404;
        #1;
        chk("t4_gnt_b", 32'(gnt), 1);
        tick();
        req = 1'b0; ack = 1'b1; dat = 32'hB1B1B1B1;
        #1;
        chk("t4_rvalid_a", 32'(rvalid), 1);
        chk("t4_err_a", 32'(rerr), 0);
        chk("t4_rdata_a", rdata, 32'hB1B1B1B1);
        tick();
        ack = 1'b0; err = 1'b1;
        #1;
        chk("t4_rvalid_b", 32'(rvalid), 1);
        chk("t4_err_b", 32'(rerr), 1);
        tick();
        err = 1'b0;
        #1;
        chk("t4_cyc_low", 32'(cyc), 0);
        chk("t4_rvalid_low", 32'(rvalid), 0);
        chk("t4_tmo", 32'(tmo), 0);

        // 5: timeout abort
        tick();
        req = 1'b1; addr = 32'h500;
        #1;
        chk("t5_gnt_a", 32'(gnt), 1);
        tick();
        addr = 32'h504;
        #1;
        chk("t5_gnt_b", 32'(gnt), 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            req = 1'b0;
            #1;
            chk("t5_cyc_wait", 32'(cyc), 1);
            chk("t5_rvalid_wait", 32'(rvalid), 0);
        end
        tick();
        dat = 32'hCAFEF00D;
        #1;
        chk("t5_cyc_abort", 32'(cyc), 0);
        chk("t5_stb_abort", 32'(stb), 0);
        chk("t5_rvalid_1", 32'(rvalid), 1);
        chk("t5_err_1", 32'(rerr), 1);
        chk("t5_rdata_1", rdata, 0);
        chk("t5_tmo", 32'(tmo), 1);
        tick();
        ack = 1'b1;
        #1;
        chk("t5_rvalid_2", 32'(rvalid), 1);
        chk("t5_err_2", 32'(rerr), 1);
        chk("t5_rdata_2", rdata, 0);
        tick();
        ack = 1'b0;
        #1;
        chk("t5_rvalid_end", 32'(rvalid), 0);
        chk("t5_cyc_end", 32'(cyc), 0);
        chk("t5_spur_late", 32'(spur), 0);
        chk("t5_tmo_sticky", 32'(tmo), 1);

        // 6: spurious ack, then reset mid-read
        tick();
        ack = 1'b1; dat = 32'h55555555;
        #1;
        chk("t6_spur_rvalid", 32'(rvalid), 0);
        tick();
        ack = 1'b0;
        #1;
        chk("t6_spur_flag", 32'(spur), 1);
        tick();
        req = 1'b1; addr = 32'h600;
        #1;
        chk("t6_gnt", 32'(gnt), 1);
        tick();
        req = 1'b0;
        #1;
        chk("t6_cyc_busy", 32'(cyc), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_cyc_rst", 32'(cyc), 0);
        chk("t6_spur_rst", 32'(spur), 0);
        chk("t6_tmo_rst", 32'(tmo), 0);
        tick();
        rst = 1'b0;
        tick();
        ack = 1'b1;
        #1;
        chk("t6_no_resp", 32'(rvalid), 0);
        tick();
        ack = 1'b0;
        #1;
        chk("t6_cnt_zero", 32'(spur), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
